// File: rtl/otter_arb_pkg.sv
// Shared types and constants for the otter_mcu fetch/data memory arbiter.
package otter_arb_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } arb_owner_t;

    localparam logic [STRB_W-1:0] FETCH_STRB = 4'hF;

endpackage

// File: rtl/otter_arb_prio.sv
// Data-over-fetch priority select with a saturating data-streak counter
// that forces a fetch grant once data has won MAX_DATA_STREAK times in a row.
module otter_arb_prio
    import otter_arb_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req,
    input  logic       d_req,
    input  logic       grant_evt,
    input  arb_owner_t grant_owner,
    output arb_owner_t sel,
    output logic       sel_vld,
    output logic [3:0] streak
);

    localparam logic [3:0] MAX_STREAK = 4'(MAX_DATA_STREAK);

    logic streak_full;

    assign streak_full = (streak == MAX_STREAK);

    always_comb begin
        sel     = OWN_FETCH;
        sel_vld = 1'b0;
        if (d_req && !(i_req && streak_full)) begin
            sel     = OWN_DATA;
            sel_vld = 1'b1;
        end else if (i_req) begin
            sel     = OWN_FETCH;
            sel_vld = 1'b1;
        end
    end

    // Streak only means anything while fetch is actually waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak <= 4'd0;
        end else if (!i_req) begin
            streak <= 4'd0;
        end else if (grant_evt && (grant_owner == OWN_FETCH)) begin
            streak <= 4'd0;
        end else if (grant_evt && (grant_owner == OWN_DATA) && !streak_full) begin
            streak <= streak + 4'd1;
        end
    end

endmodule

// File: rtl/otter_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction
// fetch and data access; responses are routed back to the owning requester.
module otter_mem_arbiter
    import otter_arb_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4,
    parameter int ADDR_W          = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [STRB_W-1:0] d_strb,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              m_req,
    output logic              m_we,
    output logic [STRB_W-1:0] m_strb,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_gnt,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,

    output logic              proto_err
);

    arb_state_t state_q, state_d;
    arb_owner_t owner_q, owner_d;
    arb_owner_t cur_owner;
    arb_owner_t sel;
    logic       sel_vld;
    logic       drive_req;
    logic       grant_evt;
    logic [3:0] streak;

    otter_arb_prio #(
        .MAX_DATA_STREAK (MAX_DATA_STREAK)
    ) u_prio (
        .clk         (clk),
        .rst         (rst),
        .i_req       (i_req),
        .d_req       (d_req),
        .grant_evt   (grant_evt),
        .grant_owner (cur_owner),
        .sel         (sel),
        .sel_vld     (sel_vld),
        .streak      (streak)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cur_owner = owner_q;
        drive_req = 1'b0;
        grant_evt = 1'b0;

        m_req     = 1'b0;
        m_we      = 1'b0;
        m_strb    = '0;
        m_addr    = '0;
        m_wdata   = '0;
        i_gnt     = 1'b0;
        d_gnt     = 1'b0;
        i_rvalid  = 1'b0;
        i_rdata   = '0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;

        unique case (state_q)
            ARB_IDLE: begin
                cur_owner = sel;
                if (sel_vld) begin
                    drive_req = 1'b1;
                    owner_d   = sel;
                    if (m_gnt) begin
                        grant_evt = 1'b1;
                        state_d   = ARB_RESP;
                    end else begin
                        state_d   = ARB_REQ;
                    end
                end
            end
            // Owner is locked in; a higher-priority arrival waits its turn.
            ARB_REQ: begin
                drive_req = 1'b1;
                if (m_gnt) begin
                    grant_evt = 1'b1;
                    state_d   = ARB_RESP;
                end
            end
            ARB_RESP: begin
                if (m_rvalid) begin
                    state_d = ARB_IDLE;
                    if (owner_q == OWN_DATA) begin
                        d_rvalid = 1'b1;
                        d_rdata  = m_rdata;
                    end else begin
                        i_rvalid = 1'b1;
                        i_rdata  = m_rdata;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        if (drive_req) begin
            m_req = 1'b1;
            if (cur_owner == OWN_DATA) begin
                m_we    = d_we;
                m_strb  = d_strb;
                m_addr  = d_addr;
                m_wdata = d_wdata;
            end else begin
                m_we    = 1'b0;
                m_strb  = FETCH_STRB;
                m_addr  = i_addr;
                m_wdata = '0;
            end
        end

        if (grant_evt) begin
            i_gnt = (cur_owner == OWN_FETCH);
            d_gnt = (cur_owner == OWN_DATA);
        end
    end

    // A response outside ARB_RESP has no owner: drop it and latch the error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            owner_q   <= OWN_FETCH;
            proto_err <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            if (m_rvalid && (state_q != ARB_RESP)) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule
